// File: rtl/router_chan_pkg.sv
// router_chan_pkg
//   Shared definitions for the router ingress channel: field positions of the
//   packed flit channel {valid, head, tail, vc, data}, the credit return word
//   {credit_valid, credit_vc}, and the packet-framing state encoding.
//   Used by the injector (sender) and the future ejector (receiver).
//   Ports: none (package).
package router_chan_pkg;

  // Number of bits needed to name one of n VCs.
  function automatic int vc_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Packed channel word, MSB to LSB: {valid, head, tail, vc[vw-1:0], data[dw-1:0]}.
  localparam int CH_DATA_LSB = 0;

  function automatic int chan_width(input int vw, input int dw);
    return 3 + vw + dw;
  endfunction

  function automatic int chan_vc_lsb(input int dw);
    return dw;
  endfunction

  function automatic int chan_tail_bit(input int vw, input int dw);
    return dw + vw;
  endfunction

  function automatic int chan_head_bit(input int vw, input int dw);
    return dw + vw + 1;
  endfunction

  function automatic int chan_valid_bit(input int vw, input int dw);
    return dw + vw + 2;
  endfunction

  // Credit return word, MSB to LSB: {credit_valid, credit_vc[vw-1:0]}.
  localparam int FC_VC_LSB = 0;

  function automatic int fc_valid_bit(input int vw);
    return vw;
  endfunction

  function automatic int fc_width(input int vw);
    return 1 + vw;
  endfunction

  // Packet framing state.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    INPKT = 1'b1
  } pkt_state_e;

  // Same encodings as plain constants for logic-typed state registers.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_INPKT = 1'b1;

endpackage

// File: rtl/router_channel_injector_if.sv
// router_channel_injector_if
//   Flit source handshake into the injector.
//   Handshake: a flit (in_head, in_tail, in_vc, in_data) transfers on every
//   rising clk edge where in_valid & in_ready are both high; the source holds
//   the flit fields stable while in_valid is high and in_ready is low, and
//   in_ready may depend on in_vc but never on in_valid.
//   Signals:
//     in_valid  source -> injector  flit valid
//     in_ready  injector -> source  selected VC has a credit
//     in_head   source -> injector  first flit of packet
//     in_tail   source -> injector  last flit of packet
//     in_vc     source -> injector  target VC
//     in_data   source -> injector  payload
//   Modports: master (traffic source), slave (injector).
interface router_channel_injector_if
  import router_chan_pkg::*;
#(
  parameter int num_vcs         = 4,
  parameter int flit_data_width = 64
);
  localparam int VW = vc_width(num_vcs);

  logic                       in_valid;
  logic                       in_ready;
  logic                       in_head;
  logic                       in_tail;
  logic [VW-1:0]              in_vc;
  logic [flit_data_width-1:0] in_data;

  modport master (
    output in_valid, in_head, in_tail, in_vc, in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_head, in_tail, in_vc, in_data,
    output in_ready
  );

endinterface

// File: rtl/router_channel_injector_credit_ctr.sv
// inj_credit_ctr
//   One per-VC credit counter. Resets to cpv (downstream buffer fully free),
//   decrements when a flit is sent on this VC, increments when the router
//   returns a credit for this VC. A simultaneous send and return leaves the
//   count unchanged. The count saturates at cpv and never wraps below zero.
//   Ports:
//     clk, reset  rising-edge clock, synchronous active-high reset
//     inc         credit returned on this VC this cycle
//     dec         flit sent on this VC this cycle (only when not empty)
//     empty       count == 0
//     overflow    inc that would push the count above cpv (combinational)
module inj_credit_ctr #(
  parameter int cpv = 16,
  parameter int cw  = $clog2(cpv + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic empty,
  output logic overflow
);

  localparam logic [cw-1:0] CPV_C = cw'(cpv);
  localparam logic [cw-1:0] ONE_C = cw'(1);

  logic [cw-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= CPV_C;
    end else if (inc && !dec && (count != CPV_C)) begin
      count <= count + ONE_C;
    end else if (dec && !inc && (count != '0)) begin
      count <= count - ONE_C;
    end
  end

  assign empty    = (count == '0);
  // A return paired with a send is always legal: the pair cancels out.
  assign overflow = inc && !dec && (count == CPV_C);

endmodule

// File: rtl/router_channel_injector.sv
// router_channel_injector
//   Credit-based flit transmitter driving one router input port channel.
//   Accepts flits from a source over a valid/ready handshake, registers each
//   accepted flit onto channel_out one cycle later, and keeps one credit
//   counter per VC so a flit is only sent when the downstream buffer of its
//   VC has room. Credits come back on flow_ctrl_in.
//   Optional feature: define INJ_ERROR_CHECK_EN to enable the sticky error
//   flag (credit overflow, missing head, unexpected head, VC change inside a
//   packet). Without it, error is tied to 0.
//   Ports:
//     clk, reset    rising-edge clock, synchronous active-high reset
//     src           slave side of the flit source handshake
//     channel_out   {valid, head, tail, vc, data} to router channel_in_ip
//     flow_ctrl_in  {credit_valid, credit_vc} from router flow_ctrl_out_ip
//     credit_avail  bit v set while VC v has at least one credit
//     error         sticky protocol/credit error
//     pkt_state     packet framing state (ST_IDLE / ST_INPKT)
module router_channel_injector
  import router_chan_pkg::*;
#(
  parameter int num_vcs         = 4,
  parameter int buffer_size     = 64,
  parameter int flit_data_width = 64,
  localparam int VW  = vc_width(num_vcs),
  localparam int CPV = buffer_size / num_vcs,
  localparam int CW  = $clog2(CPV + 1),
  localparam int CHW = chan_width(VW, flit_data_width),
  localparam int FCW = fc_width(VW)
) (
  input  logic                  clk,
  input  logic                  reset,
  router_channel_injector_if.slave src,
  output logic [CHW-1:0]        channel_out,
  input  logic [FCW-1:0]        flow_ctrl_in,
  output logic [num_vcs-1:0]    credit_avail,
  output logic                  error,
  output logic [0:0]            pkt_state
);

  localparam int CH_VALID = chan_valid_bit(VW, flit_data_width);
  localparam int FC_VALID = fc_valid_bit(VW);

  logic               credit_valid;
  logic [VW-1:0]      credit_vc;
  logic               accept;
  logic [num_vcs-1:0] inc;
  logic [num_vcs-1:0] dec;
  logic [num_vcs-1:0] empty;
  logic [num_vcs-1:0] overflow;
  logic [VW-1:0]      pkt_vc;

  assign credit_valid = flow_ctrl_in[FC_VALID];
  assign credit_vc    = flow_ctrl_in[FC_VC_LSB +: VW];

  // ---------------------------------------------------------------------------
  // Per-VC credit counters
  // ---------------------------------------------------------------------------
  for (genvar v = 0; v < num_vcs; v++) begin : g_vc
    assign inc[v] = credit_valid && (credit_vc == VW'(v));
    assign dec[v] = accept && (src.in_vc == VW'(v));

    inj_credit_ctr #(
      .cpv (CPV),
      .cw  (CW)
    ) u_ctr (
      .clk      (clk),
      .reset    (reset),
      .inc      (inc[v]),
      .dec      (dec[v]),
      .empty    (empty[v]),
      .overflow (overflow[v])
    );

    assign credit_avail[v] = !empty[v];
  end

  // Ready looks only at registered counts, so a credit returned this cycle
  // is first usable next cycle and there is no flow_ctrl_in -> in_ready path.
  assign src.in_ready = credit_avail[src.in_vc];
  assign accept       = src.in_valid && src.in_ready;

  // ---------------------------------------------------------------------------
  // Channel output register. Without an accept only the valid bit drops; the
  // other fields keep their last values to avoid needless toggling.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      channel_out <= '0;
    end else if (accept) begin
      channel_out <= {1'b1, src.in_head, src.in_tail, src.in_vc, src.in_data};
    end else begin
      channel_out[CH_VALID] <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Packet framing FSM. Tracks whether a multi-flit packet is open and which
  // VC it was opened on; single-flit packets (head+tail) never leave IDLE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_state <= ST_IDLE;
      pkt_vc    <= '0;
    end else if (accept) begin
      case (pkt_state)
        ST_IDLE: begin
          if (src.in_head && !src.in_tail) begin
            pkt_state <= ST_INPKT;
            pkt_vc    <= src.in_vc;
          end
        end
        ST_INPKT: begin
          if (src.in_tail) begin
            pkt_state <= ST_IDLE;
          end
        end
        default: pkt_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flag. Offending flits are still sent; the flag only reports.
  // ---------------------------------------------------------------------------
`ifdef INJ_ERROR_CHECK_EN
  logic err_q;
  logic err_set;

  always_comb begin
    err_set = |overflow;
    if (accept) begin
      if ((pkt_state == ST_IDLE) && !src.in_head) begin
        err_set = 1'b1;
      end
      if ((pkt_state == ST_INPKT) && src.in_head) begin
        err_set = 1'b1;
      end
      if ((pkt_state == ST_INPKT) && (src.in_vc != pkt_vc)) begin
        err_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign error = err_q;
`else
  // Overflowing returns are still dropped by the counters; nothing reports them.
  logic unused_chk;
  assign unused_chk = ^{overflow, pkt_vc};
  assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_router_channel_injector.sv
// tb_router_channel_injector
//   Directed bench for router_channel_injector (num_vcs=4, buffer_size=64,
//   flit_data_width=64). Works with and without INJ_ERROR_CHECK_EN.
module tb_router_channel_injector;
  import router_chan_pkg::*;

  localparam int NV  = 4;
  localparam int DW  = 64;
  localparam int CHW = 3 + 2 + DW;

`ifdef INJ_ERROR_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [CHW-1:0] channel_out;
  logic [2:0]     flow_ctrl_in;
  logic [NV-1:0]  credit_avail;
  logic           error;
  logic [0:0]     pkt_state;

  router_channel_injector_if #(.num_vcs(NV), .flit_data_width(DW)) src_if ();

  router_channel_injector #(
    .num_vcs         (NV),
    .buffer_size     (64),
    .flit_data_width (DW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .src          (src_if),
    .channel_out  (channel_out),
    .flow_ctrl_in (flow_ctrl_in),
    .credit_avail (credit_avail),
    .error        (error),
    .pkt_state    (pkt_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_err    = 0;
  logic [CHW-1:0] exp_q[$];

  function automatic logic [CHW-1:0] mk_ch(input logic v, input logic h, input logic t,
                                           input logic [1:0] vc, input logic [63:0] d);
    return {v, h, t, vc, d};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic drive(input logic v, input logic h, input logic t, input logic [1:0] vc,
                       input logic [63:0] d, input logic fv, input logic [1:0] fvc);
    src_if.in_valid = v;
    src_if.in_head  = h;
    src_if.in_tail  = t;
    src_if.in_vc    = vc;
    src_if.in_data  = d;
    flow_ctrl_in    = {fv, fvc};
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 64'h0, 1'b0, 2'd0);
    step();
    reset = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ch"},    channel_out, '0);
    chk({tag, "_ready"}, src_if.in_ready, 1'b1);
    chk({tag, "_avail"}, credit_avail, 4'hf);
    chk({tag, "_err"},   error, 1'b0);
    chk({tag, "_state"}, pkt_state, ST_IDLE);
  endtask

  // Offer one flit that must be accepted now and appear on the channel next cycle.
  task automatic send_flit(input string tag, input logic h, input logic t,
                           input logic [1:0] vc, input logic [63:0] d);
    drive(1'b1, h, t, vc, d, 1'b0, 2'd0);
    #1;
    chk({tag, "_ready"}, src_if.in_ready, 1'b1);
    exp_q.push_back(mk_ch(1'b1, h, t, vc, d));
    step();
    chk({tag, "_ch"}, channel_out, exp_q.pop_front());
  endtask

  // ---------------------------------------------------------------------------
  // Vector table: one record per cycle
  // ---------------------------------------------------------------------------
  typedef struct {
    logic           valid;
    logic           head;
    logic           tail;
    logic [1:0]     vc;
    logic [63:0]    data;
    logic           fc_v;
    logic [1:0]     fc_vc;
    logic           exp_ready;
    logic [CHW-1:0] exp_ch;
    logic [NV-1:0]  exp_avail;
    logic           exp_err;
    logic [0:0]     exp_state;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    // 4-flit packet on VC 0, then a body flit on VC 3 inside a VC 0 packet.
    tbl[0] = '{1'b1, 1'b1, 1'b0, 2'd0, 64'h1, 1'b0, 2'd0, 1'b1,
               mk_ch(1'b1, 1'b1, 1'b0, 2'd0, 64'h1), 4'hf, 1'b0, ST_INPKT};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 2'd0, 64'h2, 1'b0, 2'd0, 1'b1,
               mk_ch(1'b1, 1'b0, 1'b0, 2'd0, 64'h2), 4'hf, 1'b0, ST_INPKT};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 2'd0, 64'h3, 1'b0, 2'd0, 1'b1,
               mk_ch(1'b1, 1'b0, 1'b0, 2'd0, 64'h3), 4'hf, 1'b0, ST_INPKT};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 2'd0, 64'h4, 1'b0, 2'd0, 1'b1,
               mk_ch(1'b1, 1'b0, 1'b1, 2'd0, 64'h4), 4'hf, 1'b0, ST_IDLE};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 2'd0, 64'h0, 1'b0, 2'd0, 1'b1,
               mk_ch(1'b0, 1'b0, 1'b1, 2'd0, 64'h4), 4'hf, 1'b0, ST_IDLE};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 2'd0, 64'h5, 1'b0, 2'd0, 1'b1,
               mk_ch(1'b1, 1'b1, 1'b0, 2'd0, 64'h5), 4'hf, 1'b0, ST_INPKT};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 2'd3, 64'h6, 1'b0, 2'd0, 1'b1,
               mk_ch(1'b1, 1'b0, 1'b0, 2'd3, 64'h6), 4'hf, ERR_EN, ST_INPKT};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 2'd0, 64'h0, 1'b0, 2'd0, 1'b1,
               mk_ch(1'b0, 1'b0, 1'b0, 2'd3, 64'h6), 4'hf, ERR_EN, ST_INPKT};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 2'd0, 64'h0, 1'b1, 2'd0, 1'b1,
               mk_ch(1'b0, 1'b0, 1'b0, 2'd3, 64'h6), 4'hf, ERR_EN, ST_INPKT};

    // Reset values
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 64'h0, 1'b0, 2'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_state("reset");

    // Table-driven packet framing and VC-change check
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].valid, tbl[i].head, tbl[i].tail, tbl[i].vc, tbl[i].data,
            tbl[i].fc_v, tbl[i].fc_vc);
      #1;
      chk($sformatf("vec%0d_ready", i), src_if.in_ready, tbl[i].exp_ready);
      step();
      chk($sformatf("vec%0d_ch", i),    channel_out,  tbl[i].exp_ch);
      chk($sformatf("vec%0d_avail", i), credit_avail, tbl[i].exp_avail);
      chk($sformatf("vec%0d_err", i),   error,        tbl[i].exp_err);
      chk($sformatf("vec%0d_state", i), pkt_state,    tbl[i].exp_state);
    end

    // 16 back-to-back single-flit packets exhaust VC 2
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      send_flit($sformatf("burst%0d", i), 1'b1, 1'b1, 2'd2, 64'h100 + 64'(i));
    end
    drive(1'b1, 1'b1, 1'b1, 2'd2, 64'hdead, 1'b0, 2'd0);
    #1;
    chk("empty_ready", src_if.in_ready, 1'b0);
    chk("empty_avail", credit_avail, 4'b1011);
    step();
    chk("empty_hold", channel_out, mk_ch(1'b0, 1'b1, 1'b1, 2'd2, 64'h10f));

    // One credit back on VC 2: ready only the cycle after, exactly one flit
    drive(1'b1, 1'b1, 1'b1, 2'd2, 64'h200, 1'b1, 2'd2);
    #1;
    chk("ret_same_cycle_ready", src_if.in_ready, 1'b0);
    step();
    chk("ret_same_cycle_ch_valid", channel_out[CHW-1], 1'b0);
    send_flit("ret_flit", 1'b1, 1'b1, 2'd2, 64'h200);
    #1;
    chk("ret_used_ready", src_if.in_ready, 1'b0);
    chk("ret_used_avail", credit_avail, 4'b1011);
    step();
    chk("ret_used_ch_valid", channel_out[CHW-1], 1'b0);

    // VC 1 at count 5: simultaneous send and return keeps 5 credits
    apply_reset();
    for (int i = 0; i < 11; i++) begin
      send_flit($sformatf("vc1_fill%0d", i), 1'b1, 1'b1, 2'd1, 64'h300 + 64'(i));
    end
    drive(1'b1, 1'b1, 1'b1, 2'd1, 64'h3ff, 1'b1, 2'd1);
    #1;
    chk("vc1_both_ready", src_if.in_ready, 1'b1);
    step();
    chk("vc1_both_ch", channel_out, mk_ch(1'b1, 1'b1, 1'b1, 2'd1, 64'h3ff));
    for (int i = 0; i < 5; i++) begin
      send_flit($sformatf("vc1_drain%0d", i), 1'b1, 1'b1, 2'd1, 64'h400 + 64'(i));
    end
    drive(1'b1, 1'b1, 1'b1, 2'd1, 64'h4ff, 1'b0, 2'd0);
    #1;
    chk("vc1_empty_ready", src_if.in_ready, 1'b0);
    chk("vc1_empty_avail", credit_avail, 4'b1101);

    // Credit return on full VC 0 saturates at 16
    apply_reset();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 64'h0, 1'b1, 2'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 64'h0, 1'b0, 2'd0);
    chk("ovf_err", error, ERR_EN);
    chk("ovf_avail", credit_avail, 4'hf);
    for (int i = 0; i < 16; i++) begin
      send_flit($sformatf("ovf_drain%0d", i), 1'b1, 1'b1, 2'd0, 64'h500 + 64'(i));
    end
    drive(1'b1, 1'b1, 1'b1, 2'd0, 64'h5ff, 1'b0, 2'd0);
    #1;
    chk("ovf_empty_ready", src_if.in_ready, 1'b0);
    chk("ovf_err_sticky", error, ERR_EN);

    // Reset in the middle of a packet
    apply_reset();
    send_flit("mid_head", 1'b1, 1'b0, 2'd1, 64'h600);
    chk("mid_state", pkt_state, ST_INPKT);
    drive(1'b1, 1'b0, 1'b0, 2'd1, 64'h601, 1'b0, 2'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 64'h0, 1'b0, 2'd0);
    #1;
    check_reset_state("midrst");
    send_flit("post_rst", 1'b1, 1'b1, 2'd3, 64'h700);
    chk("post_rst_err", error, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
